// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared FSM state type and width helpers for the median-length engine
package median_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        ROOT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int diff_w(input int w);
        return w + 2;
    endfunction

    function automatic int sq_w(input int w);
        return 2 * w + 5;
    endfunction

    function automatic int root_w(input int w);
        return w + 3;
    endfunction

endpackage

// File: rtl/isqrt_serial.sv
// rtl/isqrt_serial.sv - serial restoring integer square root, one root bit per cycle
// The start cycle already performs the first digit step, so root is final root_w(W) cycles after start.
module isqrt_serial
    import median_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [sq_w(W)-1:0]     radicand,
    output logic                   done,
    output logic [root_w(W)-1:0]   root
);

    localparam int N  = root_w(W);
    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] rad_q, rad_d, src_rad;
    logic [N+1:0]   rem_q, rem_d, src_rem, rem_sh, trial;
    logic [N-1:0]   root_q, root_d, src_root;
    logic [CW-1:0]  cnt_q;
    logic           step;

    always_comb begin
        src_rad  = start ? {1'b0, radicand} : rad_q;
        src_rem  = start ? '0 : rem_q;
        src_root = start ? '0 : root_q;
        step     = start || (cnt_q != '0 && cnt_q != CW'(N));
        rem_sh   = (src_rem << 2) | (N+2)'(src_rad[2*N-1:2*N-2]);
        trial    = {src_root, 2'b01};
        rad_d    = src_rad << 2;
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = {src_root[N-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh;
            root_d = {src_root[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (step) begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= start ? CW'(1) : cnt_q + CW'(1);
        end
    end

    assign done = (cnt_q == CW'(N));
    assign root = root_q;

endmodule

// File: rtl/median_len_seq.sv
// rtl/median_len_seq.sv - sequential triangle median lengths, one shared square/root path
// Optional MEDIAN_SQ_OUT_EN adds sq_a/sq_b/sq_c outputs carrying the squared doubled medians.
module median_len_seq
    import median_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [W-1:0]    ax,
    input  logic signed [W-1:0]    ay,
    input  logic signed [W-1:0]    bx,
    input  logic signed [W-1:0]    by,
    input  logic signed [W-1:0]    cx,
    input  logic signed [W-1:0]    cy,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [diff_w(W)-1:0]   m_a,
    output logic [diff_w(W)-1:0]   m_b,
    output logic [diff_w(W)-1:0]   m_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
`ifdef MEDIAN_SQ_OUT_EN
    ,
    output logic [sq_w(W)-1:0]     sq_a,
    output logic [sq_w(W)-1:0]     sq_b,
    output logic [sq_w(W)-1:0]     sq_c
`endif
);

    localparam int DW = diff_w(W);
    localparam int SW = sq_w(W);
    localparam int RW = root_w(W);

    state_t state_q, state_d;
    logic [1:0] idx_q;
    logic signed [W-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic [RW-1:0] ra_q, rb_q;

    logic signed [W-1:0]    px, py, qx, qy, rx, ry;
    logic signed [DW-1:0]   dx, dy;
    logic signed [2*DW-1:0] dx_e, dy_e, dx2, dy2;
    logic [SW-1:0]          s_sum;
    logic                   accept, sq_start, root_done, root_last;
    logic [RW-1:0]          root;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign sq_start  = (state_q == SQ);
    assign root_last = (state_q == ROOT) && root_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SQ;
            SQ:      state_d = ROOT;
            ROOT:    if (root_done) state_d = (idx_q == 2'd2) ? DONE : SQ;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Rotate the vertex roles so one datapath serves all three medians.
    always_comb begin
        px = ax_q; py = ay_q;
        qx = bx_q; qy = by_q;
        rx = cx_q; ry = cy_q;
        case (idx_q)
            2'd1: begin
                px = bx_q; py = by_q;
                qx = cx_q; qy = cy_q;
                rx = ax_q; ry = ay_q;
            end
            2'd2: begin
                px = cx_q; py = cy_q;
                qx = ax_q; qy = ay_q;
                rx = bx_q; ry = by_q;
            end
            default: ;
        endcase
        dx    = (DW'(px) <<< 1) - DW'(qx) - DW'(rx);
        dy    = (DW'(py) <<< 1) - DW'(qy) - DW'(ry);
        dx_e  = (2*DW)'(dx);
        dy_e  = (2*DW)'(dy);
        dx2   = dx_e * dx_e;
        dy2   = dy_e * dy_e;
        s_sum = SW'($unsigned(dx2)) + SW'($unsigned(dy2));
    end

    isqrt_serial #(.W(W)) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand (s_sum),
        .done     (root_done),
        .root     (root)
    );

    // Roots of a and b are staged so the visible outputs change only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ax_q  <= '0; ay_q <= '0;
            bx_q  <= '0; by_q <= '0;
            cx_q  <= '0; cy_q <= '0;
            idx_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            m_a   <= '0;
            m_b   <= '0;
            m_c   <= '0;
        end else begin
            if (accept) begin
                ax_q  <= ax; ay_q <= ay;
                bx_q  <= bx; by_q <= by;
                cx_q  <= cx; cy_q <= cy;
                idx_q <= 2'd0;
            end
            if (root_last) begin
                idx_q <= idx_q + 2'd1;
                case (idx_q)
                    2'd0:    ra_q <= root;
                    2'd1:    rb_q <= root;
                    default: begin
                        m_a <= DW'(ra_q >> 1);
                        m_b <= DW'(rb_q >> 1);
                        m_c <= DW'(root >> 1);
                    end
                endcase
            end
        end
    end

`ifdef MEDIAN_SQ_OUT_EN
    logic [SW-1:0] s_q, sa_q, sb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q  <= '0;
            sa_q <= '0;
            sb_q <= '0;
            sq_a <= '0;
            sq_b <= '0;
            sq_c <= '0;
        end else begin
            if (sq_start) s_q <= s_sum;
            if (root_last) begin
                case (idx_q)
                    2'd0:    sa_q <= s_q;
                    2'd1:    sb_q <= s_q;
                    default: begin
                        sq_a <= sa_q;
                        sq_b <= sb_q;
                        sq_c <= s_q;
                    end
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_median_len_seq.sv
// tb/tb_median_len_seq.sv - scoreboard bench for median_len_seq (default or MEDIAN_SQ_OUT_EN build)
module tb_median_len_seq;

    localparam int W      = 8;
    localparam int LAT    = 3 * (W + 4);
    localparam int PERIOD = LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [W-1:0] ax, ay, bx, by, cx, cy;
    logic in_valid, in_ready, out_valid, out_ready, busy;
    logic [W+1:0] m_a, m_b, m_c;
`ifdef MEDIAN_SQ_OUT_EN
    logic [2*W+4:0] sq_a, sq_b, sq_c;
`endif

    always #5 clk = ~clk;

    median_len_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .cx        (cx),
        .cy        (cy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_c       (m_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef MEDIAN_SQ_OUT_EN
        ,
        .sq_a      (sq_a),
        .sq_b      (sq_b),
        .sq_c      (sq_c)
`endif
    );

    typedef struct {
        int ma, mb, mc;
        int sa, sb, sc;
        int acc;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int isq(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic exp_t mk(input int ma, mb, mc, sa, sbv, sc);
        exp_t e;
        e.ma = ma; e.mb = mb; e.mc = mc;
        e.sa = sa; e.sb = sbv; e.sc = sc;
        e.acc = 0;
        return e;
    endfunction

    function automatic exp_t model(input int x0, y0, x1, y1, x2, y2);
        int xs[3];
        int ys[3];
        int ss[3];
        int dx, dy, q, r;
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        ys[0] = y0; ys[1] = y1; ys[2] = y2;
        for (int k = 0; k < 3; k++) begin
            q = (k + 1) % 3;
            r = (k + 2) % 3;
            dx = 2 * xs[k] - xs[q] - xs[r];
            dy = 2 * ys[k] - ys[q] - ys[r];
            ss[k] = dx * dx + dy * dy;
        end
        return mk(isq(ss[0]) / 2, isq(ss[1]) / 2, isq(ss[2]) / 2, ss[0], ss[1], ss[2]);
    endfunction

    task automatic send(input int x0, y0, x1, y1, x2, y2, input exp_t e_in, input bit keep);
        exp_t e;
        int n;
        e  = e_in;
        ax = W'(x0); ay = W'(y0);
        bx = W'(x1); by = W'(y1);
        cx = W'(x2); cy = W'(y2);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (keep && last_acc > 0) check("b2b_period", e.acc - last_acc, PERIOD);
        last_acc = e.acc;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    // Scoreboard: checks latency on each new result and contents on each output handshake.
    initial begin
        exp_t e;
        bit prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) check("spurious_out_valid", 1, 0);
                    else                check("latency", cyc - sb[0].acc, LAT);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("m_a", m_a, e.ma);
                        check("m_b", m_b, e.mb);
                        check("m_c", m_c, e.mc);
`ifdef MEDIAN_SQ_OUT_EN
                        check("sq_a", sq_a, e.sa);
                        check("sq_b", sq_b, e.sb);
                        check("sq_c", sq_c, e.sc);
`endif
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x[6];
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;

        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_m_a", m_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(0, 0, 4, 0, 0, 4, mk(2, 4, 4, 32, 80, 80), 1'b0);
        drain();
        send(0, 0, 6, 0, 0, 8, mk(5, 7, 8, 100, 208, 292), 1'b0);
        drain();
        send(127, 127, -128, -128, -128, -128, mk(360, 180, 180, 520200, 130050, 130050), 1'b0);
        drain();
        send(5, -3, 5, -3, 5, -3, mk(0, 0, 0, 0, 0, 0), 1'b0);
        drain();

        // Backpressure: result must hold for 20 stalled cycles, then one ready cycle frees the engine.
        out_ready = 1'b0;
        send(0, 0, 6, 0, 0, 8, mk(5, 7, 8, 100, 208, 292), 1'b0);
        wait_out();
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_m_a", m_a, 5);
            check("bp_m_b", m_b, 7);
            check("bp_m_c", m_c, 8);
`ifdef MEDIAN_SQ_OUT_EN
            check("bp_sq_c", sq_c, 292);
`endif
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a computation.
        send(1, 2, 30, -7, -20, 15, model(1, 2, 30, -7, -20, 15), 1'b0);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_m_a", m_a, 0);
        check("midrst_m_b", m_b, 0);
        check("midrst_m_c", m_c, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 0, 4, 0, 0, 4, mk(2, 4, 4, 32, 80, 80), 1'b0);
        drain();

        // Continuous in_valid: back-to-back triangles against the software model.
        last_acc = 0;
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < 6; j++) x[j] = int'($urandom_range(0, 255)) - 128;
            send(x[0], x[1], x[2], x[3], x[4], x[5], model(x[0], x[1], x[2], x[3], x[4], x[5]), 1'b1);
        end
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
